// File: rtl/vpg_timing_pattern.sv
// Parametrised video timing and test-pattern source: LFSR noise, scrolling gradient, colour bars, checker.
// Optional macro VPG_BORDER_EN overlays an all-ones one-pixel border around the active area.
module vpg_timing_pattern #(
    parameter int DW           = 8,
    parameter int H_ACTIVE     = 529,
    parameter int H_SYNC_START = 544,
    parameter int H_SYNC_END   = 590,
    parameter int H_TOTAL      = 638,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 245,
    parameter int V_SYNC_END   = 248,
    parameter int V_TOTAL      = 262,
    parameter int SCROLL_STEP  = 6,
    parameter int BAR_SHIFT    = 6,
    parameter int CHK_SHIFT    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scandouble,
    input  logic [1:0]    mode,
    input  logic          pause,
    output logic          ce_pix,
    output logic          HBlank,
    output logic          HSync,
    output logic          VBlank,
    output logic          VSync,
    output logic          frame_start,
    output logic [DW-1:0] video
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(2 * V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);
    localparam logic [VW-1:0] VT_SINGLE_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VT_DOUBLE_LAST = VW'(2 * V_TOTAL - 1);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MODE_NOISE = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [15:0]   frame_cnt;
    logic [15:0]   lfsr;
    mode_t         mode_q;

    logic [VW-1:0] vl;
    logic [VW-1:0] vt_last;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_blank;
    logic          v_blank;
    logic [HW-1:0] bar_raw;
    logic [2:0]    bar_idx;
    logic [DW-1:0] scroll;
    logic [DW-1:0] pix;

    // Line-doubled mode repeats every source line, so halving vc maps back to the single-rate timing.
    assign vl      = scandouble ? (vc >> 1) : vc;
    assign vt_last = scandouble ? VT_DOUBLE_LAST : VT_SINGLE_LAST;
    assign h_wrap  = (hc == H_LAST);
    // >= lets a mid-frame drop out of scandouble wrap straight away instead of counting past the end.
    assign v_wrap  = (vc >= vt_last);
    assign h_blank = (hc >= H_ACT);
    assign v_blank = (vl >= V_ACT);
    assign bar_raw = hc >> BAR_SHIFT;
    assign bar_idx = (bar_raw > HW'(7)) ? 3'd7 : bar_raw[2:0];
    assign scroll  = DW'(frame_cnt * 16'(SCROLL_STEP));

`ifdef VPG_BORDER_EN
    logic border;
    assign border = (hc == '0) || (hc == H_ACT - 1'b1) || (vl == '0) || (vl == V_ACT - 1'b1);
`endif

    // NOTE: pix takes a default before the case, so every path assigns it and no latch is inferred.
    always_comb begin
        pix = '0;
        case (mode_q)
            MODE_NOISE: pix = lfsr[DW-1:0];
            MODE_GRAD:  pix = DW'(vl) + scroll;
            MODE_BARS:  pix = {3'd7 - bar_idx, {(DW-3){1'b0}}};
            MODE_CHECK: pix = {DW{hc[CHK_SHIFT] ^ vl[CHK_SHIFT] ^ frame_cnt[5]}};
            default:    pix = '0;
        endcase
`ifdef VPG_BORDER_EN
        if (border) pix = '1;
`endif
        if (h_blank || v_blank) pix = '0;
    end

    // NOTE: non-blocking assignments throughout, so every output below is computed from the
    // pre-edge hc/vc and video, blank and sync stay aligned with one clk of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            ce_pix      <= 1'b0;
            frame_cnt   <= '0;
            mode_q      <= MODE_NOISE;
            lfsr        <= LFSR_SEED;
            HBlank      <= 1'b0;
            HSync       <= 1'b0;
            VBlank      <= 1'b0;
            VSync       <= 1'b0;
            frame_start <= 1'b0;
            video       <= '0;
        end else begin
            ce_pix <= scandouble | ~ce_pix;
            if (ce_pix) begin
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
                if (h_wrap) begin
                    hc <= '0;
                    if (v_wrap) begin
                        vc     <= '0;
                        mode_q <= mode_t'(mode);
                        if (!pause) frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        vc <= vc + 1'b1;
                    end
                end else begin
                    hc <= hc + 1'b1;
                end
            end
            HBlank      <= h_blank;
            HSync       <= (hc >= H_SS) && (hc < H_SE);
            VBlank      <= v_blank;
            VSync       <= (vl >= V_SS) && (vl < V_SE);
            frame_start <= ce_pix && (hc == '0) && (vc == '0);
            video       <= pix;
        end
    end
endmodule

// File: tb/tb_vpg_timing_pattern.sv
// Directed bench: a default-size instance for line timing and a reduced-size instance
// (40 x 18 single-rate) so frame-level behaviour fits in a short run.
module tb_vpg_timing_pattern;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scandouble = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       b_ce, b_hb, b_hs, b_vb, b_vs, b_fs;
    logic [7:0] b_video;
    logic       s_ce, s_hb, s_hs, s_vb, s_vs, s_fs;
    logic [7:0] s_video;

    int total = 0;
    int bad   = 0;

`ifdef VPG_BORDER_EN
    localparam logic [7:0] RST_V0 = 8'hFF, RST_V1 = 8'hFF;
    localparam logic [7:0] BAR_HC0 = 8'hFF, BAR_HC29 = 8'hFF, BAR_VL11 = 8'hFF;
`else
    localparam logic [7:0] RST_V0 = 8'hE1, RST_V1 = 8'h70;
    localparam logic [7:0] BAR_HC0 = 8'hE0, BAR_HC29 = 8'h00, BAR_VL11 = 8'hC0;
`endif

    always #5 clk = ~clk;

    vpg_timing_pattern u_big (
        .clk(clk), .reset(reset), .scandouble(scandouble), .mode(mode), .pause(pause),
        .ce_pix(b_ce), .HBlank(b_hb), .HSync(b_hs), .VBlank(b_vb), .VSync(b_vs),
        .frame_start(b_fs), .video(b_video)
    );

    vpg_timing_pattern #(
        .DW(8), .H_ACTIVE(30), .H_SYNC_START(32), .H_SYNC_END(36), .H_TOTAL(40),
        .V_ACTIVE(12), .V_SYNC_START(14), .V_SYNC_END(17), .V_TOTAL(18),
        .SCROLL_STEP(6), .BAR_SHIFT(2), .CHK_SHIFT(2)
    ) u_small (
        .clk(clk), .reset(reset), .scandouble(scandouble), .mode(mode), .pause(pause),
        .ce_pix(s_ce), .HBlank(s_hb), .HSync(s_hs), .VBlank(s_vb), .VSync(s_vs),
        .frame_start(s_fs), .video(s_video)
    );

    typedef struct {
        int         k;
        logic [7:0] vid;
        logic       hb;
        logic       hs;
        logic       vb;
    } vec_t;

    task automatic do_reset(input logic sd, input logic [1:0] md);
        reset = 1'b1; scandouble = sd; mode = md; pause = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_fs !== 1'b1 && n < limit);
        total++;
        if (s_fs !== 1'b1) begin
            bad++;
            $display("FAIL %s: frame_start=%b after %0d clks, want 1", name, s_fs, n);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, 2'd0);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({b_ce, b_hb, b_hs, b_vb, b_vs, b_fs, b_video} !== 14'h0) begin
            bad++; $display("FAIL reset_big: got %h want 0", {b_ce, b_hb, b_hs, b_vb, b_vs, b_fs, b_video});
        end
        total++;
        if ({s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_video} !== 14'h0) begin
            bad++; $display("FAIL reset_small: got %h want 0", {s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_video});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({b_ce, b_fs, b_video} !== {2'b10, RST_V0}) begin
            bad++; $display("FAIL edge1: ce/fs/video got %b/%b/%h want 1/0/%h", b_ce, b_fs, b_video, RST_V0);
        end
        @(negedge clk);
        total++;
        if ({b_ce, b_fs, b_video} !== {2'b01, RST_V0}) begin
            bad++; $display("FAIL edge2: ce/fs/video got %b/%b/%h want 0/1/%h", b_ce, b_fs, b_video, RST_V0);
        end
        @(negedge clk);
        total++;
        if ({b_ce, b_fs, b_video} !== {2'b10, RST_V1}) begin
            bad++; $display("FAIL edge3: ce/fs/video got %b/%b/%h want 1/0/%h", b_ce, b_fs, b_video, RST_V1);
        end
    endtask

    task automatic test_line_timing();
        int   rise0 = -1, rise1 = -1, hb_cnt = 0, hs_cnt = 0, ce_same = 0;
        logic prev_hb = 1'b0, prev_ce = 1'b0;
        do_reset(1'b0, 2'd0);
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            if (b_hb === 1'b1 && prev_hb === 1'b0) begin
                if (rise0 < 0) rise0 = i;
                else if (rise1 < 0) rise1 = i;
            end
            if (rise0 >= 0 && rise1 < 0) begin
                hb_cnt += int'(b_hb);
                hs_cnt += int'(b_hs);
            end
            if (i > 0 && b_ce === prev_ce) ce_same++;
            prev_hb = b_hb;
            prev_ce = b_ce;
        end
        total++;
        if (rise1 - rise0 != 1276) begin
            bad++; $display("FAIL line_period: got %0d want 1276", rise1 - rise0);
        end
        total++;
        if (hb_cnt != 218) begin
            bad++; $display("FAIL hblank_width: got %0d want 218", hb_cnt);
        end
        total++;
        if (hs_cnt != 92) begin
            bad++; $display("FAIL hsync_width: got %0d want 92", hs_cnt);
        end
        total++;
        if (ce_same != 0) begin
            bad++; $display("FAIL ce_toggle: non-toggling clks got %0d want 0", ce_same);
        end
    endtask

    task automatic test_big_scandouble();
        int ce_low = 0, hs_cnt = 0;
        do_reset(1'b1, 2'd2);
        for (int j = 1; j <= 700; j++) begin
            @(negedge clk);
            if (b_ce !== 1'b1) ce_low++;
            hs_cnt += int'(b_hs);
            if (j inside {530, 531}) begin
                total++;
                if (b_hb !== logic'(j == 531)) begin
                    bad++; $display("FAIL sd_hblank hc=%0d: got %b want %b", j - 2, b_hb, j == 531);
                end
            end
            if (j inside {545, 546, 591, 592}) begin
                total++;
                if (b_hs !== logic'(j >= 546 && j < 592)) begin
                    bad++; $display("FAIL sd_hsync hc=%0d: got %b want %b", j - 2, b_hs, j >= 546 && j < 592);
                end
            end
        end
        total++;
        if (ce_low != 0) begin
            bad++; $display("FAIL sd_ce: low clks got %0d want 0", ce_low);
        end
        total++;
        if (hs_cnt != 46) begin
            bad++; $display("FAIL sd_hsync_width: got %0d want 46", hs_cnt);
        end
    endtask

    task automatic test_bars();
        vec_t vecs[11] = '{
            '{400, BAR_HC0,  1'b0, 1'b0, 1'b0}, '{404, 8'hC0, 1'b0, 1'b0, 1'b0},
            '{412, 8'h80,    1'b0, 1'b0, 1'b0}, '{429, BAR_HC29, 1'b0, 1'b0, 1'b0},
            '{430, 8'h00,    1'b1, 1'b0, 1'b0}, '{431, 8'h00, 1'b1, 1'b0, 1'b0},
            '{432, 8'h00,    1'b1, 1'b1, 1'b0}, '{435, 8'h00, 1'b1, 1'b1, 1'b0},
            '{436, 8'h00,    1'b1, 1'b0, 1'b0}, '{925, BAR_VL11, 1'b0, 1'b0, 1'b0},
            '{965, 8'h00,    1'b0, 1'b0, 1'b1}
        };
        int vs_cnt, vb_cnt, hb_cnt, ce_low, vs_first;
        do_reset(1'b1, 2'd2);
        wait_fs("bars_fs0", 10);
        wait_fs("bars_fs1", 2000);
        vs_cnt = int'(s_vs); vb_cnt = int'(s_vb); hb_cnt = int'(s_hb);
        ce_low = 0; vs_first = -1;
        for (int k = 1; k < 1440; k++) begin
            @(negedge clk);
            vs_cnt += int'(s_vs); vb_cnt += int'(s_vb); hb_cnt += int'(s_hb);
            if (s_ce !== 1'b1) ce_low++;
            if (s_vs === 1'b1 && vs_first < 0) vs_first = k;
            for (int t = 0; t < 11; t++) begin
                if (vecs[t].k == k) begin
                    total++;
                    if (s_video !== vecs[t].vid) begin
                        bad++; $display("FAIL bars_video k=%0d: got %h want %h", k, s_video, vecs[t].vid);
                    end
                    total++;
                    if ({s_hb, s_hs, s_vb} !== {vecs[t].hb, vecs[t].hs, vecs[t].vb}) begin
                        bad++; $display("FAIL bars_flags k=%0d: hb/hs/vb got %b%b%b want %b%b%b",
                                        k, s_hb, s_hs, s_vb, vecs[t].hb, vecs[t].hs, vecs[t].vb);
                    end
                end
            end
        end
        total++;
        if (vs_cnt != 240 || vs_first != 1120) begin
            bad++; $display("FAIL sd_vsync: count/first got %0d/%0d want 240/1120", vs_cnt, vs_first);
        end
        total++;
        if (vb_cnt != 480 || hb_cnt != 360) begin
            bad++; $display("FAIL sd_blank: vb/hb got %0d/%0d want 480/360", vb_cnt, hb_cnt);
        end
        total++;
        if (ce_low != 0) begin
            bad++; $display("FAIL small_sd_ce: low clks got %0d want 0", ce_low);
        end
    endtask

    task automatic test_gradient_pause();
        logic [7:0] exp_v[6] = '{8'd8, 8'd14, 8'd20, 8'd20, 8'd20, 8'd20};
        do_reset(1'b1, 2'd1);
        wait_fs("grad_fs0", 10);
        for (int f = 0; f < 6; f++) begin
            wait_fs("grad_fs", 2000);
            skip(203);
            total++;
            if (s_video !== exp_v[f]) begin
                bad++; $display("FAIL gradient frame%0d: got %0d want %0d", f, s_video, exp_v[f]);
            end
            if (f == 2) pause = 1'b1;
        end
        pause = 1'b0;
    endtask

    task automatic test_mode_change();
        int noisy = 0;
        do_reset(1'b1, 2'd0);
        wait_fs("mc_fs0", 10);
        wait_fs("mc_fs1", 2000);
        skip(800);
        mode = 2'd3;
        for (int k = 0; k < 29; k++) begin
            @(negedge clk);
            if (s_video !== 8'h00 && s_video !== 8'hFF) noisy++;
        end
        total++;
        if (noisy == 0) begin
            bad++; $display("FAIL mode_hold: noise-like pixels got %0d want >0", noisy);
        end
        wait_fs("mc_fs2", 2000);
        skip(81);
        total++;
        if (s_video !== 8'h00) begin bad++; $display("FAIL checker(1,1): got %h want 00", s_video); end
        skip(2);
        total++;
        if (s_video !== 8'h00) begin bad++; $display("FAIL checker(3,1): got %h want 00", s_video); end
        skip(1);
        total++;
        if (s_video !== 8'hFF) begin bad++; $display("FAIL checker(4,1): got %h want FF", s_video); end
        skip(4);
        total++;
        if (s_video !== 8'h00) begin bad++; $display("FAIL checker(8,1): got %h want 00", s_video); end
        skip(233);
        total++;
        if (s_video !== 8'hFF) begin bad++; $display("FAIL checker(1,4): got %h want FF", s_video); end
        mode = 2'd0;
    endtask

    task automatic test_scandouble_toggle();
        int n = 0, vs_cnt = 0, run = 0, max_run = 0, xs = 0;
        do_reset(1'b1, 2'd0);
        wait_fs("sdt_fs0", 10);
        wait_fs("sdt_fs1", 2000);
        skip(1200);
        scandouble = 1'b0;
        do begin
            @(negedge clk);
            n++;
            vs_cnt += int'(s_vs);
            if ($isunknown({s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_video})) xs++;
        end while (s_fs !== 1'b1 && n < 200);
        total++;
        if (n != 79 || s_fs !== 1'b1) begin
            bad++; $display("FAIL sd_drop_wrap: frame_start after %0d clks, want 79", n);
        end
        total++;
        if (vs_cnt != 0) begin
            bad++; $display("FAIL sd_drop_vsync: got %0d clks want 0", vs_cnt);
        end
        n = 0; vs_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            vs_cnt += int'(s_vs);
            run = (s_vs === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if ($isunknown({s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_video})) xs++;
        end while (s_fs !== 1'b1 && n < 3000);
        total++;
        if (n != 1440) begin
            bad++; $display("FAIL single_rate_frame: got %0d clks want 1440", n);
        end
        total++;
        if (vs_cnt != 240 || max_run != 240) begin
            bad++; $display("FAIL single_rate_vsync: count/run got %0d/%0d want 240/240", vs_cnt, max_run);
        end
        total++;
        if (xs != 0) begin
            bad++; $display("FAIL no_x: unknown samples got %0d want 0", xs);
        end
        scandouble = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_big_scandouble();
        test_bars();
        test_gradient_pause();
        test_mode_change();
        test_scandouble_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
